// File: rtl/rf_alu_pkg.sv
// Shared constants for the rf_alu datapath: widths, register count, ALU opcodes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rf_alu_pkg;

    localparam int NREG = 8;
    localparam int W    = 16;
    localparam int AW   = $clog2(NREG);

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_ADC = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_SBB = 2'b11;

    // Subtract-type ops share the ~B path; bit 1 of the opcode marks them.
    function automatic logic is_sub(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/rf_alu_if.sv
// Decoder-side bundle for rf_alu: addresses, controls, immediates, load/link data, read/ALU/flag outputs.
// Latency: n/a (wiring only).
// Backpressure: none; the datapath accepts one instruction per clock.
interface rf_alu_if;
    import rf_alu_pkg::*;

    logic          WE;
    logic [AW-1:0] RdAddr;
    logic [AW-1:0] RnAddr;
    logic [AW-1:0] RmAddr;
    logic          S_Rn_or_Rd;
    logic [1:0]    ALUctrl;
    logic          ALUsrc;
    logic [4:0]    imm5;
    logic [7:0]    imm8;
    logic          MOV;
    logic          ALU2Rd;
    logic          LHI;
    logic          LLI;
    logic          MemoryW;
    logic          PCW;
    logic [W-1:0]  Memory_data;
    logic [W-1:0]  PC_data;
    logic [W-1:0]  RD1;
    logic [W-1:0]  RD2;
    logic [W-1:0]  Result;
    logic          C;
    logic          V;
    logic          N;
    logic          Z;

    // slave: the datapath itself
    modport slave (
        input  WE, RdAddr, RnAddr, RmAddr, S_Rn_or_Rd, ALUctrl, ALUsrc,
               imm5, imm8, MOV, ALU2Rd, LHI, LLI, MemoryW, PCW,
               Memory_data, PC_data,
        output RD1, RD2, Result, C, V, N, Z
    );

    // master: decoder / memory / PC side
    modport master (
        output WE, RdAddr, RnAddr, RmAddr, S_Rn_or_Rd, ALUctrl, ALUsrc,
               imm5, imm8, MOV, ALU2Rd, LHI, LLI, MemoryW, PCW,
               Memory_data, PC_data,
        input  RD1, RD2, Result, C, V, N, Z
    );

endinterface

// File: rtl/rf_alu_alu16.sv
// 16-bit add/subtract ALU (ADD/ADC/SUB/SBB) producing result and raw NZCV.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b operands; op opcode; cin carry flag in; result, c, v, n, z out.
module alu16
    import rf_alu_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    input  logic         cin,
    output logic [W-1:0] result,
    output logic         c,
    output logic         v,
    output logic         n,
    output logic         z
);

    logic [W-1:0] b_eff;
    logic         c_in_eff;
    logic [W:0]   sum;

    // SUB uses a fixed +1 (two's complement); SBB reuses the carry flag so
    // that C=1 means "no borrow" across a multi-word subtract chain.
    always_comb begin
        b_eff    = is_sub(op) ? ~b : b;
        c_in_eff = 1'b0;
        case (op)
            ALU_ADD: c_in_eff = 1'b0;
            ALU_ADC: c_in_eff = cin;
            ALU_SUB: c_in_eff = 1'b1;
            ALU_SBB: c_in_eff = cin;
            default: c_in_eff = 1'b0;
        endcase
    end

    assign sum    = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, c_in_eff};
    assign result = sum[W-1:0];
    assign c      = sum[W];
    // Overflow: operands (as actually added) agree in sign, result does not.
    assign v      = (a[W-1] == b_eff[W-1]) && (result[W-1] != a[W-1]);
    assign n      = result[W-1];
    assign z      = (result == '0);

endmodule

// File: rtl/rf_alu.sv
// CPU datapath core: 8x16 register file, NZCV ALU and prioritized write-back selector.
// Latency: reads/ALU combinational; register and flag writes take effect at the next rising edge.
// Backpressure: none; one write per clock, CLR overrides any write.
// Ports: CLK, CLR (sync, active-high); bus carries addresses/controls in and RD1/RD2/Result/flags out.
module rf_alu
    import rf_alu_pkg::*;
(
    input  logic     CLK,
    input  logic     CLR,
    rf_alu_if.slave  bus
);

    logic [W-1:0]  rf [NREG];
    logic [AW-1:0] rd2_addr;
    logic [W-1:0]  alu_b;
    logic [W-1:0]  alu_res;
    logic          alu_c;
    logic          alu_v;
    logic          alu_n;
    logic          alu_z;
    logic [W-1:0]  wr_dat;
    logic          wr_en;
    logic          flag_en;
    logic          c_q;
    logic          v_q;
    logic          n_q;
    logic          z_q;

    // Asynchronous reads, no bypass: same-cycle write is visible only after the edge.
    assign rd2_addr = bus.S_Rn_or_Rd ? bus.RdAddr : bus.RmAddr;
    assign bus.RD1  = rf[bus.RnAddr];
    assign bus.RD2  = rf[rd2_addr];

    assign alu_b = bus.ALUsrc ? {{(W-5){1'b0}}, bus.imm5} : bus.RD2;

    alu16 u_alu (
        .a      (bus.RD1),
        .b      (alu_b),
        .op     (bus.ALUctrl),
        .cin    (c_q),
        .result (alu_res),
        .c      (alu_c),
        .v      (alu_v),
        .n      (alu_n),
        .z      (alu_z)
    );

    assign bus.Result = alu_res;

    // Write-back source, highest priority first.
    always_comb begin
        wr_dat  = '0;
        wr_en   = 1'b0;
        flag_en = 1'b0;
        if (bus.MemoryW) begin
            wr_dat = bus.Memory_data;
            wr_en  = bus.WE;
        end else if (bus.PCW) begin
            wr_dat = bus.PC_data;
            wr_en  = bus.WE;
        end else if (bus.LHI) begin
            wr_dat = {bus.imm8, bus.RD2[7:0]};
            wr_en  = bus.WE;
        end else if (bus.LLI) begin
            wr_dat = {8'h00, bus.imm8};
            wr_en  = bus.WE;
        end else if (bus.ALU2Rd) begin
            wr_dat  = alu_res;
            wr_en   = bus.WE;
            // Flags only follow an ALU result that is actually written back.
            flag_en = bus.WE;
        end else if (bus.MOV) begin
            wr_dat = bus.RD2;
            wr_en  = bus.WE;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_en) begin
            rf[bus.RdAddr] <= wr_dat;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            c_q <= 1'b0;
            v_q <= 1'b0;
            n_q <= 1'b0;
            z_q <= 1'b0;
        end else if (flag_en) begin
            c_q <= alu_c;
            v_q <= alu_v;
            n_q <= alu_n;
            z_q <= alu_z;
        end
    end

    assign bus.C = c_q;
    assign bus.V = v_q;
    assign bus.N = n_q;
    assign bus.Z = z_q;

endmodule

// File: tb/tb_rf_alu.sv
// Self-checking bench for rf_alu: directed program plus randomized instructions vs. an arithmetic model.
// Latency: checks combinational outputs before each edge, flags after it.
// Backpressure: n/a.
module tb_rf_alu;
    import rf_alu_pkg::*;

    logic CLK = 1'b0;
    logic CLR;
    always #5 CLK = ~CLK;

    rf_alu_if bus ();

    rf_alu dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus.slave)
    );

    int vecs = 0;
    int errs = 0;

    logic [15:0] mreg [8];
    logic        mc, mv, mn, mz;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // sel = {MemoryW, PCW, LHI, LLI, ALU2Rd, MOV}
    task automatic drive(input logic we, input logic [2:0] rd, input logic [2:0] rn,
                         input logic [2:0] rm, input logic s, input logic [1:0] op,
                         input logic src, input logic [4:0] i5, input logic [7:0] i8,
                         input logic [5:0] sel, input logic [15:0] md, input logic [15:0] pc);
        bus.WE          = we;
        bus.RdAddr      = rd;
        bus.RnAddr      = rn;
        bus.RmAddr      = rm;
        bus.S_Rn_or_Rd  = s;
        bus.ALUctrl     = op;
        bus.ALUsrc      = src;
        bus.imm5        = i5;
        bus.imm8        = i8;
        bus.MemoryW     = sel[5];
        bus.PCW         = sel[4];
        bus.LHI         = sel[3];
        bus.LLI         = sel[2];
        bus.ALU2Rd      = sel[1];
        bus.MOV         = sel[0];
        bus.Memory_data = md;
        bus.PC_data     = pc;
    endtask

    // Called just after a falling edge with inputs applied; returns at the next falling edge.
    task automatic cycle();
        logic [15:0] a, b, p2, res, wd;
        int          ua, ub, ci, s, sa, sb, ss;
        logic        c, v, wen, fen;
        a  = mreg[bus.RnAddr];
        p2 = mreg[bus.S_Rn_or_Rd ? bus.RdAddr : bus.RmAddr];
        b  = bus.ALUsrc ? {11'b0, bus.imm5} : p2;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        ci = mc ? 1 : 0;
        case (bus.ALUctrl)
            2'b00:   begin s = ua + ub;            ss = sa + sb;            end
            2'b01:   begin s = ua + ub + ci;       ss = sa + sb + ci;       end
            2'b10:   begin s = ua - ub;            ss = sa - sb;            end
            default: begin s = ua - ub - (1 - ci); ss = sa - sb - (1 - ci); end
        endcase
        res = s[15:0];
        c   = bus.ALUctrl[1] ? (s >= 0) : (s > 65535);
        v   = (ss > 32767) || (ss < -32768);

        #1;
        chk("rd1", bus.RD1, a);
        chk("rd2", bus.RD2, p2);
        chk("result", bus.Result, res);

        wen = bus.WE;
        fen = 1'b0;
        if (bus.MemoryW)     wd = bus.Memory_data;
        else if (bus.PCW)    wd = bus.PC_data;
        else if (bus.LHI)    wd = {bus.imm8, p2[7:0]};
        else if (bus.LLI)    wd = {8'h00, bus.imm8};
        else if (bus.ALU2Rd) begin wd = res; fen = bus.WE; end
        else if (bus.MOV)    wd = p2;
        else begin wd = '0; wen = 1'b0; end

        @(posedge CLK);
        #1;
        if (CLR) begin
            for (int i = 0; i < 8; i++) mreg[i] = '0;
            {mc, mv, mn, mz} = 4'b0;
        end else begin
            if (wen) mreg[bus.RdAddr] = wd;
            if (fen) begin
                mc = c;
                mv = v;
                mn = res[15];
                mz = (res == 16'h0);
            end
        end
        chk("flags_cvnz", {12'h0, bus.C, bus.V, bus.N, bus.Z}, {12'h0, mc, mv, mn, mz});
        @(negedge CLK);
    endtask

    // Read every register on both ports with writes disabled.
    task automatic sweep();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 3'd0, 3'(i), 3'(7 - i), 1'b0, 2'b00, 1'b0, 5'd0, 8'd0, 6'b0, 16'h0, 16'h0);
            #1;
            chk("sweep_rd1", bus.RD1, mreg[i]);
            chk("sweep_rd2", bus.RD2, mreg[7 - i]);
        end
        @(negedge CLK);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mreg[i] = 16'hDEAD;
        {mc, mv, mn, mz} = 4'b0;
        CLR = 1'b1;
        drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 2'b00, 1'b0, 5'd0, 8'd0, 6'b0, 16'h0, 16'h0);
        @(posedge CLK);
        #1;
        for (int i = 0; i < 8; i++) mreg[i] = '0;
        CLR = 1'b0;
        @(negedge CLK);
        chk("reset_flags", {12'h0, bus.C, bus.V, bus.N, bus.Z}, 16'h0);
        sweep();

        // Fill R0..R7 = 0x0011*(i+1) via the load path
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 3'd0, 3'd0, 1'b0, 2'b00, 1'b0, 5'd0, 8'd0, 6'b100000,
                  16'(16'h0011 * (i + 1)), 16'h0);
            cycle();
        end
        sweep();
        chk("fill_r7", mreg[7], 16'h0088);

        drive(1'b1, 3'd0, 3'd0, 3'd0, 1'b1, 2'b00, 1'b0, 5'd0, 8'h00, 6'b001000, 16'h0, 16'h0); cycle();
        drive(1'b1, 3'd1, 3'd0, 3'd0, 1'b0, 2'b00, 1'b0, 5'd0, 8'h78, 6'b000100, 16'h0, 16'h0); cycle();
        drive(1'b1, 3'd2, 3'd0, 3'd0, 1'b0, 2'b00, 1'b0, 5'd0, 8'h00, 6'b100000, 16'h0001, 16'h0); cycle();
        drive(1'b1, 3'd4, 3'd2, 3'd1, 1'b0, ALU_ADD, 1'b0, 5'd0, 8'h0, 6'b000010, 16'h0, 16'h0); cycle();
        drive(1'b1, 3'd5, 3'd3, 3'd2, 1'b0, ALU_ADC, 1'b0, 5'd0, 8'h0, 6'b000010, 16'h0, 16'h0); cycle();
        drive(1'b1, 3'd6, 3'd4, 3'd3, 1'b0, ALU_SUB, 1'b0, 5'd0, 8'h0, 6'b000010, 16'h0, 16'h0); cycle();
        drive(1'b1, 3'd7, 3'd5, 3'd4, 1'b0, ALU_SBB, 1'b0, 5'd0, 8'h0, 6'b000010, 16'h0, 16'h0); cycle();
        chk("sbb_nc", {14'h0, bus.N, bus.C}, 16'h0002);
        drive(1'b1, 3'd7, 3'd7, 3'd0, 1'b0, ALU_ADD, 1'b1, 5'h0F, 8'h0, 6'b000010, 16'h0, 16'h0); cycle();
        drive(1'b1, 3'd6, 3'd6, 3'd0, 1'b0, ALU_SUB, 1'b1, 5'h0F, 8'h0, 6'b000010, 16'h0, 16'h0); cycle();
        chk("subi_c", {15'h0, bus.C}, 16'h0001);
        sweep();
        chk("r4_add", mreg[4], 16'h0079);
        chk("r7_addi", mreg[7], 16'hFFDB);
        chk("r6_subi", mreg[6], 16'h0026);

        // Write control: WE=0, then PCW outranking ALU2Rd
        drive(1'b0, 3'd3, 3'd7, 3'd7, 1'b0, ALU_ADD, 1'b0, 5'd0, 8'h0, 6'b000010, 16'h0, 16'h0); cycle();
        drive(1'b1, 3'd0, 3'd7, 3'd7, 1'b0, ALU_ADD, 1'b0, 5'd0, 8'h0, 6'b010010, 16'h0, 16'h1234); cycle();
        sweep();

        // Signed overflow 0x7FFF + 1
        drive(1'b1, 3'd1, 3'd0, 3'd0, 1'b0, 2'b00, 1'b0, 5'd0, 8'h0, 6'b100000, 16'h7FFF, 16'h0); cycle();
        drive(1'b1, 3'd2, 3'd1, 3'd0, 1'b0, ALU_ADD, 1'b1, 5'd1, 8'h0, 6'b000010, 16'h0, 16'h0); cycle();
        chk("ovf_vn", {14'h0, bus.V, bus.N}, 16'h0003);

        // Reset concurrent with a write
        CLR = 1'b1;
        drive(1'b1, 3'd5, 3'd0, 3'd0, 1'b0, 2'b00, 1'b0, 5'd0, 8'h0, 6'b100000, 16'hBEEF, 16'h0); cycle();
        CLR = 1'b0;
        sweep();

        // Randomized instruction stream
        for (int n = 0; n < 400; n++) begin
            logic [5:0] sel;
            for (int k = 0; k < 6; k++) sel[k] = ($urandom_range(0, 3) == 0);
            CLR = ($urandom_range(0, 39) == 0);
            drive(($urandom_range(0, 3) != 0), 3'($urandom), 3'($urandom), 3'($urandom),
                  1'($urandom), 2'($urandom), 1'($urandom), 5'($urandom), 8'($urandom),
                  sel, 16'($urandom), 16'($urandom));
            cycle();
            CLR = 1'b0;
            if (n % 50 == 49) sweep();
        end
        sweep();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
